// File: rtl/fp16_pkg.sv
// FP16 format constants, the unpacked operand type and the unpack helper
// shared by the accumulator datapath.
package fp16_pkg;

  localparam int EXP_W    = 5;
  localparam int FRAC_W   = 10;
  localparam int EXP_BIAS = 15;
  localparam int EXP_MAX  = 31;
  localparam int GUARD_W  = 3;

  localparam logic [15:0] FP16_POS_ZERO = 16'h0000;
  localparam logic [15:0] FP16_POS_INF  = 16'h7C00;
  localparam logic [15:0] FP16_QNAN     = 16'h7E00;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W:0]   sig;
    logic              is_zero;
    logic              is_inf;
  } fp16_op_t;

  // exp=0 is zero whatever the fraction holds; exp=31 is infinity likewise
  function automatic fp16_op_t fp16_unpack(input logic [15:0] v);
    fp16_op_t o;
    o.sign    = v[15];
    o.exp     = v[14:10];
    o.is_zero = (v[14:10] == '0);
    o.is_inf  = (v[14:10] == EXP_W'(EXP_MAX));
    o.sig     = o.is_zero ? '0 : {1'b1, v[9:0]};
    return o;
  endfunction

endpackage

// File: rtl/fp16_lzd.sv
// 15-bit leading-zero counter; returns 15 for an all-zero input.
module fp16_lzd (
  input  logic [14:0] val,
  output logic [3:0]  lz
);

  // ascending scan: the highest set bit is the last one to assign
  always_comb begin
    lz = 4'd15;
    for (int i = 0; i < 15; i++) begin
      if (val[i]) lz = 4'(14 - i);
    end
  end

endmodule

// File: rtl/fp16_accum_seq.sv
// Sequential FP16 accumulator: sums a LAST-terminated stream of products with
// a four-step (accept/align/add/normalize) adder and reports one sum per group.
//
// state | meaning
// IDLE  | ready for a term
// ALIGN | unpack term and accumulator, align significands
// ADD   | signed magnitude add/subtract
// NORM  | normalize, resolve specials, write accumulator
// HOLD  | result valid, waiting for OUT_READY_i
module fp16_accum_seq
  import fp16_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             IN_VALID_i,
  output logic             IN_READY_o,
  input  logic [15:0]      PROD_i,
  input  logic             LAST_i,
  output logic             OUT_VALID_o,
  input  logic             OUT_READY_i,
  output logic [15:0]      SUM_o,
  output logic [CNT_W-1:0] COUNT_o
);

  localparam int ALN_W = FRAC_W + 1 + GUARD_W;
  localparam int MAG_W = ALN_W + 1;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, HOLD} state_t;

  state_t             state, state_nx;
  logic [15:0]        acc, term;
  logic [CNT_W-1:0]   cnt;
  logic               last_q;
  logic [ALN_W-1:0]   aln_t, aln_a, aln_t_d, aln_a_d, t_ext, a_ext;
  logic [EXP_W-1:0]   exp_q, exp_big, diff;
  logic [MAG_W-1:0]   mag_q, mag_d, nrm;
  logic               sign_q, sign_d;
  logic [3:0]         lz, sh;
  logic signed [6:0]  e_res;
  logic [FRAC_W-1:0]  frac;
  logic [15:0]        res;
  fp16_op_t           op_t, op_a;

  assign op_t = fp16_unpack(term);
  assign op_a = fp16_unpack(acc);

  always_comb begin
    t_ext   = op_t.is_zero ? '0 : {op_t.sig, {GUARD_W{1'b0}}};
    a_ext   = op_a.is_zero ? '0 : {op_a.sig, {GUARD_W{1'b0}}};
    diff    = '0;
    exp_big = '0;
    aln_t_d = '0;
    aln_a_d = '0;
    if (op_t.exp >= op_a.exp) begin
      diff    = op_t.exp - op_a.exp;
      exp_big = op_t.exp;
      aln_t_d = t_ext;
      aln_a_d = (diff >= EXP_W'(ALN_W)) ? '0 : (a_ext >> diff);
    end else begin
      diff    = op_a.exp - op_t.exp;
      exp_big = op_a.exp;
      aln_a_d = a_ext;
      aln_t_d = (diff >= EXP_W'(ALN_W)) ? '0 : (t_ext >> diff);
    end
  end

  always_comb begin
    mag_d  = '0;
    sign_d = op_t.sign;
    if (op_t.sign == op_a.sign) begin
      mag_d  = {1'b0, aln_t} + {1'b0, aln_a};
      sign_d = op_t.sign;
    end else if (aln_t >= aln_a) begin
      mag_d  = {1'b0, aln_t - aln_a};
      sign_d = op_t.sign;
    end else begin
      mag_d  = {1'b0, aln_a - aln_t};
      sign_d = op_a.sign;
    end
  end

  fp16_lzd u_lzd (
    .val (mag_q),
    .lz  (lz)
  );

  // carry-out shifts right by one; otherwise bring the leading one to bit 13
  always_comb begin
    sh    = lz - 4'd1;
    nrm   = mag_q << sh;
    frac  = '0;
    e_res = '0;
    if (mag_q[MAG_W-1]) begin
      frac  = FRAC_W'(mag_q >> (GUARD_W + 1));
      e_res = $signed({2'b00, exp_q}) + 7'sd1;
    end else begin
      frac  = FRAC_W'(nrm >> GUARD_W);
      e_res = $signed({2'b00, exp_q}) - $signed({3'b000, sh});
    end

    if (op_t.is_inf && op_a.is_inf && (op_t.sign != op_a.sign))
      res = FP16_QNAN;
    else if (op_a.is_inf)
      res = FP16_POS_INF | {op_a.sign, 15'd0};
    else if (op_t.is_inf)
      res = FP16_POS_INF | {op_t.sign, 15'd0};
    else if (mag_q == '0)
      res = FP16_POS_ZERO;
    else if (e_res < 7'sd1)
      res = FP16_POS_ZERO;
    else if (e_res >= $signed(7'(EXP_MAX)))
      res = FP16_POS_INF | {sign_q, 15'd0};
    else
      res = {sign_q, e_res[EXP_W-1:0], frac};
  end

  always_comb begin
    state_nx    = state;
    IN_READY_o  = 1'b0;
    OUT_VALID_o = 1'b0;
    case (state)
      IDLE: begin
        IN_READY_o = 1'b1;
        if (IN_VALID_i) state_nx = ALIGN;
      end
      ALIGN: state_nx = ADD;
      ADD:   state_nx = NORM;
      NORM:  state_nx = last_q ? HOLD : IDLE;
      HOLD: begin
        OUT_VALID_o = 1'b1;
        if (OUT_READY_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state  <= IDLE;
      acc    <= FP16_POS_ZERO;
      cnt    <= '0;
      term   <= '0;
      last_q <= 1'b0;
      aln_t  <= '0;
      aln_a  <= '0;
      exp_q  <= '0;
      mag_q  <= '0;
      sign_q <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (IN_VALID_i) begin
            term   <= PROD_i;
            last_q <= LAST_i;
            if (cnt != '1) cnt <= cnt + CNT_W'(1);
          end
        end
        ALIGN: begin
          aln_t <= aln_t_d;
          aln_a <= aln_a_d;
          exp_q <= exp_big;
        end
        ADD: begin
          mag_q  <= mag_d;
          sign_q <= sign_d;
        end
        NORM: acc <= res;
        HOLD: begin
          if (OUT_READY_i) begin
            acc <= FP16_POS_ZERO;
            cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign SUM_o   = acc;
  assign COUNT_o = cnt;

endmodule

// File: tb/tb_fp16_accum_seq.sv
// Self-checking bench for fp16_accum_seq: directed cases plus random groups
// checked against an arithmetic reference model of the FP16 accumulation rules.
module tb_fp16_accum_seq;
  import fp16_pkg::*;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        IN_VALID_i = 1'b0;
  logic        LAST_i = 1'b0;
  logic        OUT_READY_i = 1'b0;
  logic [15:0] PROD_i = 16'h0000;
  logic        IN_READY_o, OUT_VALID_o;
  logic [15:0] SUM_o;
  logic [7:0]  COUNT_o;

  fp16_accum_seq #(.CNT_W(8)) dut (
    .CLK(CLK), .RSTN(RSTN), .IN_VALID_i(IN_VALID_i), .IN_READY_o(IN_READY_o),
    .PROD_i(PROD_i), .LAST_i(LAST_i), .OUT_VALID_o(OUT_VALID_o),
    .OUT_READY_i(OUT_READY_i), .SUM_o(SUM_o), .COUNT_o(COUNT_o)
  );

  always #5 CLK = ~CLK;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [15:0] grp [0:299];
  int          grp_n;
  logic [15:0] r_sum;
  logic [7:0]  r_cnt;
  int          r_lat;

  // Value-level model: align to the larger exponent with 3 guard bits,
  // signed integer sum, renormalize, truncate.
  function automatic logic [15:0] model_add(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, e, ma, mb, v, m;
    logic s;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    if (ea == 31 && eb == 31 && a[15] != b[15]) return 16'h7E00;
    if (ea == 31) return {a[15], 5'h1F, 10'h000};
    if (eb == 31) return {b[15], 5'h1F, 10'h000};
    ma = (ea == 0) ? 0 : (1024 + int'(a[9:0])) * 8;
    mb = (eb == 0) ? 0 : (1024 + int'(b[9:0])) * 8;
    e  = (ea > eb) ? ea : eb;
    ma = (e - ea >= 14) ? 0 : (ma >> (e - ea));
    mb = (e - eb >= 14) ? 0 : (mb >> (e - eb));
    v  = (a[15] ? -ma : ma) + (b[15] ? -mb : mb);
    s  = (v < 0);
    m  = s ? -v : v;
    if (m == 0) return 16'h0000;
    while (m >= 16384) begin m = m >> 1; e++; end
    while (m < 8192)   begin m = m << 1; e--; end
    if (e < 1)  return 16'h0000;
    if (e >= 31) return {s, 5'h1F, 10'h000};
    return {s, 5'(e), 10'(m >> 3)};
  endfunction

  task automatic wait_ready();
    int k = 0;
    while (IN_READY_o !== 1'b1 && k < 20) begin
      @(posedge CLK); #1; k++;
    end
    if (IN_READY_o !== 1'b1) begin
      n_cmp++; n_mis++;
      $display("FAIL wait_ready: IN_READY_o=%b after %0d cycles, want 1", IN_READY_o, k);
    end
  endtask

  // Sends grp[0..grp_n-1]; captures result, latency; holds OUT_READY_i low
  // for 'hold' cycles (optionally pushing a term) then releases it.
  task automatic run_group(input int hold, input bit push);
    for (int i = 0; i < grp_n; i++) begin
      wait_ready();
      IN_VALID_i = 1'b1;
      PROD_i     = grp[i];
      LAST_i     = (i == grp_n - 1);
      @(posedge CLK); #1;
      IN_VALID_i = 1'b0;
      LAST_i     = 1'b0;
    end
    r_lat = 0;
    while (OUT_VALID_o !== 1'b1 && r_lat < 20) begin
      @(posedge CLK); #1; r_lat++;
    end
    r_sum = SUM_o;
    r_cnt = COUNT_o;
    IN_VALID_i = push;
    PROD_i     = 16'h5555;
    for (int h = 0; h < hold; h++) begin
      @(posedge CLK); #1;
      n_cmp++;
      if (SUM_o !== r_sum || COUNT_o !== r_cnt || OUT_VALID_o !== 1'b1 || IN_READY_o !== 1'b0) begin
        n_mis++;
        $display("FAIL hold_stable: sum=%h cnt=%0d ov=%b ir=%b, want sum=%h cnt=%0d ov=1 ir=0",
                 SUM_o, COUNT_o, OUT_VALID_o, IN_READY_o, r_sum, r_cnt);
      end
    end
    OUT_READY_i = 1'b1;
    @(posedge CLK); #1;
    OUT_READY_i = 1'b0;
    IN_VALID_i  = 1'b0;
    n_cmp++;
    if (OUT_VALID_o !== 1'b0 || IN_READY_o !== 1'b1) begin
      n_mis++;
      $display("FAIL release: ov=%b ir=%b, want ov=0 ir=1", OUT_VALID_o, IN_READY_o);
    end
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++;
    if (IN_READY_o !== 1'b1 || OUT_VALID_o !== 1'b0 || SUM_o !== 16'h0000 || COUNT_o !== 8'd0) begin
      n_mis++;
      $display("FAIL reset_hold: ir=%b ov=%b sum=%h cnt=%0d, want 1 0 0000 0",
               IN_READY_o, OUT_VALID_o, SUM_o, COUNT_o);
    end
    @(negedge CLK) RSTN = 1'b1;
    @(posedge CLK); #1;
    n_cmp++;
    if (IN_READY_o !== 1'b1 || OUT_VALID_o !== 1'b0 || SUM_o !== 16'h0000 || COUNT_o !== 8'd0) begin
      n_mis++;
      $display("FAIL reset_release: ir=%b ov=%b sum=%h cnt=%0d, want 1 0 0000 0",
               IN_READY_o, OUT_VALID_o, SUM_o, COUNT_o);
    end
    IN_VALID_i = 1'b1; PROD_i = 16'h4000; LAST_i = 1'b0;
    @(posedge CLK); #1;
    IN_VALID_i = 1'b0;
    n_cmp++;
    if (IN_READY_o !== 1'b0 || COUNT_o !== 8'd1) begin
      n_mis++;
      $display("FAIL accept_before_reset: ir=%b cnt=%0d, want ir=0 cnt=1", IN_READY_o, COUNT_o);
    end
    RSTN = 1'b0;
    @(posedge CLK); #1;
    n_cmp++;
    if (IN_READY_o !== 1'b1 || OUT_VALID_o !== 1'b0 || SUM_o !== 16'h0000 || COUNT_o !== 8'd0) begin
      n_mis++;
      $display("FAIL reset_mid_align: ir=%b ov=%b sum=%h cnt=%0d, want 1 0 0000 0",
               IN_READY_o, OUT_VALID_o, SUM_o, COUNT_o);
    end
    #2 RSTN = 1'b1;
    grp[0] = 16'h3C00; grp_n = 1;
    run_group(0, 1'b0);
    n_cmp++;
    if (r_sum !== 16'h3C00 || r_cnt !== 8'd1) begin
      n_mis++;
      $display("FAIL after_reset_group: sum=%h cnt=%0d, want 3c00 1", r_sum, r_cnt);
    end
  endtask

  task automatic test_add_pair();
    grp[0] = 16'h4000; grp[1] = 16'h3E00; grp_n = 2;
    run_group(1, 1'b0);
    n_cmp++;
    if (r_sum !== 16'h4300 || r_cnt !== 8'd2) begin
      n_mis++;
      $display("FAIL add_pair: sum=%h cnt=%0d, want 4300 2", r_sum, r_cnt);
    end
    n_cmp++;
    if (r_lat !== 3) begin
      n_mis++;
      $display("FAIL latency: edges=%0d, want 3", r_lat);
    end
  endtask

  task automatic test_special();
    logic [15:0] ca [0:7];
    logic [15:0] cb [0:7];
    logic [15:0] ce [0:7];
    int          cn [0:7];
    ca[0] = 16'h4180; cb[0] = 16'hC180; cn[0] = 2; ce[0] = 16'h0000;
    ca[1] = 16'h7C00; cb[1] = 16'hFC00; cn[1] = 2; ce[1] = 16'h7E00;
    ca[2] = 16'h7BFF; cb[2] = 16'h7BFF; cn[2] = 2; ce[2] = 16'h7C00;
    ca[3] = 16'h3C00; cb[3] = 16'h1000; cn[3] = 2; ce[3] = 16'h3C00;
    ca[4] = 16'h3C00; cb[4] = 16'h1400; cn[4] = 2; ce[4] = 16'h3C01;
    ca[5] = 16'h0200; cb[5] = 16'h0000; cn[5] = 1; ce[5] = 16'h0000;
    ca[6] = 16'h7C01; cb[6] = 16'h0000; cn[6] = 1; ce[6] = 16'h7C00;
    ca[7] = 16'hFC00; cb[7] = 16'h3C00; cn[7] = 2; ce[7] = 16'hFC00;
    for (int c = 0; c < 8; c++) begin
      grp[0] = ca[c]; grp[1] = cb[c]; grp_n = cn[c];
      run_group(0, 1'b0);
      n_cmp++;
      if (r_sum !== ce[c] || r_cnt !== 8'(cn[c]) || r_lat !== 3) begin
        n_mis++;
        $display("FAIL special_%0d: sum=%h cnt=%0d lat=%0d, want sum=%h cnt=%0d lat=3",
                 c, r_sum, r_cnt, r_lat, ce[c], cn[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] one;
    one = {1'b0, 5'(EXP_BIAS), 10'd0};
    grp[0] = 16'h4000; grp[1] = 16'h3E00; grp_n = 2;
    run_group(5, 1'b1);
    n_cmp++;
    if (r_sum !== 16'h4300 || r_cnt !== 8'd2) begin
      n_mis++;
      $display("FAIL bp_first: sum=%h cnt=%0d, want 4300 2", r_sum, r_cnt);
    end
    grp[0] = one; grp[1] = one; grp_n = 2;
    run_group(0, 1'b0);
    n_cmp++;
    if (r_sum !== 16'h4000 || r_cnt !== 8'd2) begin
      n_mis++;
      $display("FAIL bp_next_group: sum=%h cnt=%0d, want 4000 2", r_sum, r_cnt);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 259; i++) grp[i] = 16'h0000;
    grp[259] = 16'h3C00;
    grp_n = 260;
    run_group(0, 1'b0);
    n_cmp++;
    if (r_sum !== 16'h3C00 || r_cnt !== 8'd255) begin
      n_mis++;
      $display("FAIL count_saturate: sum=%h cnt=%0d, want 3c00 255", r_sum, r_cnt);
    end
  endtask

  task automatic test_random();
    logic [15:0] exp_sum, t;
    int          kind, e;
    for (int g = 0; g < 40; g++) begin
      grp_n   = int'($urandom_range(1, 6));
      exp_sum = 16'h0000;
      for (int i = 0; i < grp_n; i++) begin
        kind = int'($urandom_range(0, 11));
        if (kind == 0)      e = 0;
        else if (kind == 1) e = 31;
        else if (kind == 2) e = int'($urandom_range(1, 30));
        else                e = int'($urandom_range(10, 20));
        t = {1'($urandom_range(0, 1)), 5'(e), 10'($urandom)};
        grp[i]  = t;
        exp_sum = model_add(exp_sum, t);
      end
      run_group(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      n_cmp++;
      if (r_sum !== exp_sum || r_cnt !== 8'(grp_n) || r_lat !== 3) begin
        n_mis++;
        $display("FAIL random_%0d: sum=%h cnt=%0d lat=%0d, want sum=%h cnt=%0d lat=3",
                 g, r_sum, r_cnt, r_lat, exp_sum, grp_n);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add_pair();
    test_special();
    test_backpressure();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
